// File: rtl/shift_reg_sipo_framed_pkg.sv
// Shared definitions for the framed serial-in/parallel-out shift register:
// default word length and shift-direction encodings.
package shift_reg_sipo_framed_pkg;

    localparam int WIDTH_DEF = 4;

    typedef enum logic {
        DIR_LEFT  = 1'b0,   // new bit enters at LSB, first bit ends at MSB
        DIR_RIGHT = 1'b1    // new bit enters at MSB, first bit ends at LSB
    } dir_e;

endpackage

// File: rtl/shift_reg_sipo_framed_if.sv
// Bus bundle for the framed SIPO: serial input controls, live shift state and
// the word output with its valid/ack handshake and sticky overrun flag.
interface shift_reg_sipo_framed_if
    import shift_reg_sipo_framed_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
);
    localparam int CNT_W = $clog2(WIDTH);

    logic             clr;
    logic             en;
    logic             sdi;
    logic             dir;
    logic [WIDTH-1:0] q;
    logic [CNT_W-1:0] bit_cnt;
    logic [WIDTH-1:0] dout;
    logic             dout_valid;
    logic             dout_ack;
    logic             overrun;

    // Producer of serial data and consumer of words
    modport master (
        output clr, en, sdi, dir, dout_ack,
        input  q, bit_cnt, dout, dout_valid, overrun
    );

    // The shift register itself
    modport slave (
        input  clr, en, sdi, dir, dout_ack,
        output q, bit_cnt, dout, dout_valid, overrun
    );

endinterface

// File: rtl/shift_reg_sipo_framed_bidir.sv
// WIDTH-bit bidirectional shift register. Besides the registered contents it
// exposes the value q will take at the next edge so the parent can capture a
// completed word on the same edge as its final shift.
module shift_reg_bidir
    import shift_reg_sipo_framed_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clr,
    input  logic             en,
    input  logic             dir,
    input  logic             sdi,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] q_next
);

    logic [WIDTH-1:0] q_r;
    logic [WIDTH-1:0] q_nxt_s;

    // Next register value: clear wins, otherwise shift in the selected direction
    always_comb begin
        q_nxt_s = q_r;
        if (clr) begin
            q_nxt_s = {WIDTH{1'b0}};
        end else if (en) begin
            if (dir == DIR_RIGHT) begin
                q_nxt_s = {sdi, q_r[WIDTH-1:1]};
            end else begin
                q_nxt_s = {q_r[WIDTH-2:0], sdi};
            end
        end else begin
            q_nxt_s = q_r;
        end
    end

    // Shift register state
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q_r <= {WIDTH{1'b0}};
        end else begin
            q_r <= q_nxt_s;
        end
    end

    assign q      = q_r;
    assign q_next = q_nxt_s;

endmodule

// File: rtl/shift_reg_sipo_framed.sv
// Framed SIPO top: shifts serial data, counts bits per word, captures each
// completed word into dout with a valid/ack handshake and a sticky overrun
// flag raised when a word overwrites one that was never acknowledged.
module shift_reg_sipo_framed
    import shift_reg_sipo_framed_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic                           clk,
    input  logic                           reset_n,
    shift_reg_sipo_framed_if.slave         bus
);

    localparam int               CNT_W   = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1'b1);

    logic [WIDTH-1:0] q_s;
    logic [WIDTH-1:0] q_next_s;

    logic [CNT_W-1:0] bit_cnt_r;
    logic [CNT_W-1:0] bit_cnt_nxt_s;
    logic [WIDTH-1:0] dout_r;
    logic [WIDTH-1:0] dout_nxt_s;
    logic             dout_valid_r;
    logic             dout_valid_nxt_s;
    logic             overrun_r;
    logic             overrun_nxt_s;
    logic             last_bit_s;

    shift_reg_bidir #(
        .WIDTH (WIDTH)
    ) u_shift (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (bus.clr),
        .en      (bus.en),
        .dir     (bus.dir),
        .sdi     (bus.sdi),
        .q       (q_s),
        .q_next  (q_next_s)
    );

    // A word completes when the bit being shifted in is the last of the word
    always_comb begin
        last_bit_s = 1'b0;
        if (bus.en && (bit_cnt_r == CNT_MAX)) begin
            last_bit_s = 1'b1;
        end else begin
            last_bit_s = 1'b0;
        end
    end

    // Bit counter, word capture, handshake and overrun next-state
    always_comb begin
        bit_cnt_nxt_s    = bit_cnt_r;
        dout_nxt_s       = dout_r;
        dout_valid_nxt_s = dout_valid_r;
        overrun_nxt_s    = overrun_r;
        if (bus.clr) begin
            bit_cnt_nxt_s    = {CNT_W{1'b0}};
            dout_nxt_s       = {WIDTH{1'b0}};
            dout_valid_nxt_s = 1'b0;
            overrun_nxt_s    = 1'b0;
        end else begin
            if (last_bit_s) begin
                bit_cnt_nxt_s    = {CNT_W{1'b0}};
                // capture includes the bit shifted in on this edge
                dout_nxt_s       = q_next_s;
                dout_valid_nxt_s = 1'b1;
                if (dout_valid_r && !bus.dout_ack) begin
                    overrun_nxt_s = 1'b1;
                end else begin
                    overrun_nxt_s = overrun_r;
                end
            end else begin
                if (bus.en) begin
                    bit_cnt_nxt_s = bit_cnt_r + CNT_ONE;
                end else begin
                    bit_cnt_nxt_s = bit_cnt_r;
                end
                if (dout_valid_r && bus.dout_ack) begin
                    dout_valid_nxt_s = 1'b0;
                end else begin
                    dout_valid_nxt_s = dout_valid_r;
                end
            end
        end
    end

    // Counter, capture and status registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bit_cnt_r    <= {CNT_W{1'b0}};
            dout_r       <= {WIDTH{1'b0}};
            dout_valid_r <= 1'b0;
            overrun_r    <= 1'b0;
        end else begin
            bit_cnt_r    <= bit_cnt_nxt_s;
            dout_r       <= dout_nxt_s;
            dout_valid_r <= dout_valid_nxt_s;
            overrun_r    <= overrun_nxt_s;
        end
    end

    assign bus.q          = q_s;
    assign bus.bit_cnt    = bit_cnt_r;
    assign bus.dout       = dout_r;
    assign bus.dout_valid = dout_valid_r;
    assign bus.overrun    = overrun_r;

endmodule

// File: tb/tb_shift_reg_sipo_framed.sv
// Self-checking bench for shift_reg_sipo_framed (WIDTH=4, 1 us clock).
// Per-cycle vector table with hand-derived expectations, a word scoreboard
// fed from the driven serial stream, and hand-written async-reset sequences.
`timescale 1ns/1ps
module tb_shift_reg_sipo_framed;

    typedef struct {
        logic       clr;
        logic       en;
        logic       sdi;
        logic       dir;
        logic       ack;
        logic [3:0] q;
        logic [1:0] cnt;
        logic [3:0] dout;
        logic       v;
        logic       o;
    } vec_t;

    logic clk;
    logic reset_n;
    int   n_cmp;
    int   n_mis;

    vec_t       tbl[$];
    logic [3:0] sb_q[$];
    logic [3:0] m_q;
    int         m_cnt;
    logic       prev_valid;
    logic [3:0] prev_dout;

    shift_reg_sipo_framed_if #(.WIDTH(4)) bus ();

    shift_reg_sipo_framed #(.WIDTH(4)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #500 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic add(input logic clr, input logic en, input logic sdi, input logic dir,
                       input logic ack, input logic [3:0] q, input logic [1:0] cnt,
                       input logic [3:0] dout, input logic v, input logic o);
        vec_t r;
        r.clr = clr; r.en = en; r.sdi = sdi; r.dir = dir; r.ack = ack;
        r.q = q; r.cnt = cnt; r.dout = dout; r.v = v; r.o = o;
        tbl.push_back(r);
    endtask

    task automatic model_reset();
        m_q        = 4'h0;
        m_cnt      = 0;
        prev_valid = 1'b0;
        prev_dout  = 4'h0;
        sb_q.delete();
    endtask

    // Drive one cycle, advance the stream model, then check outputs and scoreboard
    task automatic apply(input vec_t r, input string tag);
        @(negedge clk);
        bus.clr      = r.clr;
        bus.en       = r.en;
        bus.sdi      = r.sdi;
        bus.dir      = r.dir;
        bus.dout_ack = r.ack;
        if (r.clr) begin
            m_q   = 4'h0;
            m_cnt = 0;
        end else if (r.en) begin
            m_q = r.dir ? {r.sdi, m_q[3:1]} : {m_q[2:0], r.sdi};
            if (m_cnt == 3) begin
                sb_q.push_back(m_q);
                m_cnt = 0;
            end else begin
                m_cnt++;
            end
        end
        @(posedge clk);
        #1;
        check({tag, "_q"},    32'(bus.q),          32'(r.q));
        check({tag, "_cnt"},  32'(bus.bit_cnt),    32'(r.cnt));
        check({tag, "_dout"}, 32'(bus.dout),       32'(r.dout));
        check({tag, "_vld"},  32'(bus.dout_valid), 32'(r.v));
        check({tag, "_ovr"},  32'(bus.overrun),    32'(r.o));
        if (bus.dout_valid && (!prev_valid || bus.dout != prev_dout)) begin
            if (sb_q.size() == 0) begin
                n_cmp++;
                n_mis++;
                $display("FAIL sb_unexpected: got word %0h expected none", bus.dout);
            end else begin
                check("sb_word", 32'(bus.dout), 32'(sb_q.pop_front()));
            end
        end
        prev_valid = bus.dout_valid;
        prev_dout  = bus.dout;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_q"},    32'(bus.q),          32'd0);
        check({tag, "_cnt"},  32'(bus.bit_cnt),    32'd0);
        check({tag, "_dout"}, 32'(bus.dout),       32'd0);
        check({tag, "_vld"},  32'(bus.dout_valid), 32'd0);
        check({tag, "_ovr"},  32'(bus.overrun),    32'd0);
    endtask

    initial begin
        vec_t r;
        n_cmp = 0;
        n_mis = 0;
        model_reset();
        bus.clr = 1'b0; bus.en = 1'b0; bus.sdi = 1'b0; bus.dir = 1'b0; bus.dout_ack = 1'b0;
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("por");
        @(negedge clk);
        reset_n = 1'b1;

        // Async reset mid-stream: fill a word, start the next, then reset between edges
        r = '{clr:1'b0, en:1'b1, sdi:1'b1, dir:1'b0, ack:1'b0,
              q:4'h1, cnt:2'd1, dout:4'h0, v:1'b0, o:1'b0};
        apply(r, "ar1");
        r.q = 4'h3; r.cnt = 2'd2; apply(r, "ar2");
        r.q = 4'h7; r.cnt = 2'd3; apply(r, "ar3");
        r.q = 4'hF; r.cnt = 2'd0; r.dout = 4'hF; r.v = 1'b1; apply(r, "ar4");
        r.q = 4'hF; r.cnt = 2'd1; apply(r, "ar5");
        bus.en = 1'b0;
        #200;
        reset_n = 1'b0;
        #1;
        check_all_zero("async_rst");
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        check("rel_cnt", 32'(bus.bit_cnt), 32'd0);
        check("rel_vld", 32'(bus.dout_valid), 32'd0);

        //   clr  en   sdi  dir  ack   q     cnt   dout  v     o
        // left shift 1,0,1,1 then ack
        add(1'b0,1'b1,1'b1,1'b0,1'b0, 4'h1,2'd1,4'h0,1'b0,1'b0);
        add(1'b0,1'b1,1'b0,1'b0,1'b0, 4'h2,2'd2,4'h0,1'b0,1'b0);
        add(1'b0,1'b1,1'b1,1'b0,1'b0, 4'h5,2'd3,4'h0,1'b0,1'b0);
        add(1'b0,1'b1,1'b1,1'b0,1'b0, 4'hB,2'd0,4'hB,1'b1,1'b0);
        add(1'b0,1'b0,1'b0,1'b0,1'b1, 4'hB,2'd0,4'hB,1'b0,1'b0);
        // right shift 1,0,1,1 with en gaps
        add(1'b0,1'b1,1'b1,1'b1,1'b0, 4'hD,2'd1,4'hB,1'b0,1'b0);
        add(1'b0,1'b0,1'b0,1'b1,1'b0, 4'hD,2'd1,4'hB,1'b0,1'b0);
        add(1'b0,1'b1,1'b0,1'b1,1'b0, 4'h6,2'd2,4'hB,1'b0,1'b0);
        add(1'b0,1'b0,1'b1,1'b1,1'b0, 4'h6,2'd2,4'hB,1'b0,1'b0);
        add(1'b0,1'b1,1'b1,1'b1,1'b0, 4'hB,2'd3,4'hB,1'b0,1'b0);
        add(1'b0,1'b1,1'b1,1'b1,1'b0, 4'hD,2'd0,4'hD,1'b1,1'b0);
        add(1'b0,1'b0,1'b0,1'b1,1'b1, 4'hD,2'd0,4'hD,1'b0,1'b0);
        // 0xA then 0x5 without ack -> overrun; then clr
        add(1'b0,1'b1,1'b1,1'b0,1'b0, 4'hB,2'd1,4'hD,1'b0,1'b0);
        add(1'b0,1'b1,1'b0,1'b0,1'b0, 4'h6,2'd2,4'hD,1'b0,1'b0);
        add(1'b0,1'b1,1'b1,1'b0,1'b0, 4'hD,2'd3,4'hD,1'b0,1'b0);
        add(1'b0,1'b1,1'b0,1'b0,1'b0, 4'hA,2'd0,4'hA,1'b1,1'b0);
        add(1'b0,1'b1,1'b0,1'b0,1'b0, 4'h4,2'd1,4'hA,1'b1,1'b0);
        add(1'b0,1'b1,1'b1,1'b0,1'b0, 4'h9,2'd2,4'hA,1'b1,1'b0);
        add(1'b0,1'b1,1'b0,1'b0,1'b0, 4'h2,2'd3,4'hA,1'b1,1'b0);
        add(1'b0,1'b1,1'b1,1'b0,1'b0, 4'h5,2'd0,4'h5,1'b1,1'b1);
        add(1'b1,1'b1,1'b1,1'b0,1'b0, 4'h0,2'd0,4'h0,1'b0,1'b0);
        // 0x3 then 0xC with ack in word-2 completion cycle; late ack ignored
        add(1'b0,1'b1,1'b0,1'b0,1'b0, 4'h0,2'd1,4'h0,1'b0,1'b0);
        add(1'b0,1'b1,1'b0,1'b0,1'b0, 4'h0,2'd2,4'h0,1'b0,1'b0);
        add(1'b0,1'b1,1'b1,1'b0,1'b0, 4'h1,2'd3,4'h0,1'b0,1'b0);
        add(1'b0,1'b1,1'b1,1'b0,1'b0, 4'h3,2'd0,4'h3,1'b1,1'b0);
        add(1'b0,1'b1,1'b1,1'b0,1'b0, 4'h7,2'd1,4'h3,1'b1,1'b0);
        add(1'b0,1'b1,1'b1,1'b0,1'b0, 4'hF,2'd2,4'h3,1'b1,1'b0);
        add(1'b0,1'b1,1'b0,1'b0,1'b0, 4'hE,2'd3,4'h3,1'b1,1'b0);
        add(1'b0,1'b1,1'b0,1'b0,1'b1, 4'hC,2'd0,4'hC,1'b1,1'b0);
        add(1'b0,1'b0,1'b0,1'b0,1'b1, 4'hC,2'd0,4'hC,1'b0,1'b0);
        add(1'b0,1'b0,1'b0,1'b0,1'b1, 4'hC,2'd0,4'hC,1'b0,1'b0);
        // clr together with en on the last bit of a word: no capture
        add(1'b0,1'b1,1'b1,1'b0,1'b0, 4'h9,2'd1,4'hC,1'b0,1'b0);
        add(1'b0,1'b1,1'b1,1'b0,1'b0, 4'h3,2'd2,4'hC,1'b0,1'b0);
        add(1'b0,1'b1,1'b1,1'b0,1'b0, 4'h7,2'd3,4'hC,1'b0,1'b0);
        add(1'b1,1'b1,1'b1,1'b0,1'b0, 4'h0,2'd0,4'h0,1'b0,1'b0);

        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i], $sformatf("v%0d", i));
        end

        check("sb_drain", 32'(sb_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
